// File: rtl/mips_dump_pkg.sv
// Shared types and constants for the data-memory dump streamer.
package mips_dump_pkg;

    localparam int unsigned DM_WORD_W      = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BIDX_W         = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        SEND    = 3'd3,
        FIN     = 3'd4
    } dump_state_e;

endpackage

// File: rtl/dump_byte_ser.sv
// Loads one 32-bit word and presents it MSB-first, one byte per valid/ready handshake.
module dump_byte_ser
    import mips_dump_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [DM_WORD_W-1:0] load_data,
    input  logic                 ready,
    output logic [BYTE_W-1:0]    data,
    output logic                 valid,
    output logic                 last_c
);

    logic [DM_WORD_W-1:0] word_q, word_d;
    logic [BIDX_W-1:0]    idx_q, idx_d;
    logic                 valid_q, valid_d;

    // Shift left on each accepted byte so the current byte always sits in the top lane.
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            word_d  = load_data;
            idx_d   = BIDX_W'(BYTES_PER_WORD - 1);
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            word_d = {word_q[DM_WORD_W-BYTE_W-1:0], BYTE_W'(0)};
            if (idx_q == '0) begin
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q - BIDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign data   = word_q[DM_WORD_W-1 -: BYTE_W];
    assign valid  = valid_q;
    assign last_c = (idx_q == '0);

endmodule

// File: rtl/dm_dump_streamer.sv
// Reads a block of DM words over the synchronous read port and streams them as bytes.
module dm_dump_streamer
    import mips_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     word_cnt,
    input  logic                 abort,
    output logic                 dm_rd_en,
    output logic [ADDR_W-1:0]    dm_addr,
    input  logic [DM_WORD_W-1:0] dm_rdata,
    output logic [BYTE_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              dm_rd_en_q, dm_rd_en_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ser_load_c;
    logic              ser_clear_c;
    logic              ser_last_c;
    logic              ser_valid;
    logic [BYTE_W-1:0] ser_data;
    logic              hs_c;

    assign hs_c = ser_valid && out_ready;

    // Next state; abort outranks everything once a dump is underway.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        ser_load_c  = 1'b0;
        ser_clear_c = 1'b0;
        if (abort && (state_q != IDLE) && (state_q != FIN)) begin
            state_d     = FIN;
            ser_clear_c = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_d  = base_addr;
                        rem_d   = word_cnt;
                        state_d = (word_cnt == '0) ? FIN : RD_REQ;
                    end
                end
                RD_REQ:  state_d = RD_WAIT;
                RD_WAIT: begin
                    ser_load_c = 1'b1;
                    state_d    = SEND;
                end
                SEND: begin
                    if (hs_c && ser_last_c) begin
                        rem_d   = rem_q - CNT_W'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = (rem_q == CNT_W'(1)) ? FIN : RD_REQ;
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register in step with it.
        dm_rd_en_d = (state_d == RD_REQ);
        dm_addr_d  = dm_rd_en_d ? addr_d : dm_addr_q;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            dm_rd_en_q <= 1'b0;
            dm_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            dm_rd_en_q <= dm_rd_en_d;
            dm_addr_q  <= dm_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    dump_byte_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load_c),
        .clear     (ser_clear_c),
        .load_data (dm_rdata),
        .ready     (out_ready),
        .data      (ser_data),
        .valid     (ser_valid),
        .last_c    (ser_last_c)
    );

    assign dm_rd_en  = dm_rd_en_q;
    assign dm_addr   = dm_addr_q;
    assign out_data  = ser_data;
    assign out_valid = ser_valid;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
